// File: rtl/pheap_lvl_ctrl.sv
// One level of a pipelined heap: reads the level's slot and its two children,
// then resolves ENQ / DEQ / ENQ_DEQ for that slot and hands the displaced item on.
module pheap_lvl_ctrl #(
  parameter int LEVEL    = 2,
  parameter int KW       = 16,
  parameter int VW       = 16,
  parameter int CAPW     = 8,
  parameter int MAX_HEAP = 1,
  parameter int LAST     = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [1:0]                op,
  input  logic [LEVEL-2:0]          start_pos,
  input  logic [KW+VW-1:0]          in_kv,
  input  logic [CAPW+KW+VW:0]       r_top,
  input  logic [CAPW+KW+VW:0]       r_bot_l,
  input  logic [CAPW+KW+VW:0]       r_bot_r,
  output logic [LEVEL-2:0]          raddr_top,
  output logic [LEVEL-1:0]          raddr_bot,
  output logic                      wen_top,
  output logic [LEVEL-2:0]          waddr_top,
  output logic [CAPW+KW+VW:0]       wdata,
  output logic                      busy,
  output logic [1:0]                done,
  output logic [LEVEL-1:0]          end_pos,
  output logic [KW+VW-1:0]          out_kv,
  output logic                      ovf,
  output logic                      udf
);

  localparam int KVW = KW + VW;
  localparam int EW  = 1 + CAPW + KVW;

  localparam logic [1:0] OP_NOP     = 2'd0;
  localparam logic [1:0] OP_ENQ     = 2'd1;
  localparam logic [1:0] OP_DEQ     = 2'd2;
  localparam logic [1:0] OP_ENQ_DEQ = 2'd3;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_EVAL = 2'd2;

  localparam logic [1:0] D_WAIT = 2'd0;
  localparam logic [1:0] D_DONE = 2'd1;
  localparam logic [1:0] D_NEXT = 2'd2;

  localparam logic [CAPW-1:0] CAP_ZERO = {CAPW{1'b0}};
  localparam logic [CAPW-1:0] CAP_ONE  = {{(CAPW-1){1'b0}}, 1'b1};
  localparam logic [CAPW-1:0] CAP_MAX  = {CAPW{1'b1}};

  logic [1:0]       state_r;
  logic [1:0]       op_r;
  logic [LEVEL-2:0] pos_r;
  logic [KVW-1:0]   kv_r;

  // Ordering rule: active beats inactive, ties keep the first argument.
  function automatic logic better(input logic a_act, input logic [KW-1:0] a_key,
                                  input logic b_act, input logic [KW-1:0] b_key);
    logic res;
    if (a_act != b_act) begin
      res = a_act;
    end else if (!a_act) begin
      res = 1'b1;
    end else if (MAX_HEAP != 0) begin
      res = (a_key >= b_key);
    end else begin
      res = (a_key <= b_key);
    end
    return res;
  endfunction

  // Sequencer: accept a command in IDLE, then one read cycle and one evaluate cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
      op_r    <= OP_NOP;
      pos_r   <= {(LEVEL-1){1'b0}};
      kv_r    <= {KVW{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start && (op != OP_NOP)) begin
            state_r <= S_RD;
            op_r    <= op;
            pos_r   <= start_pos;
            kv_r    <= in_kv;
          end
        end
        S_RD:    state_r <= S_EVAL;
        S_EVAL:  state_r <= S_IDLE;
        default: state_r <= S_IDLE;
      endcase
    end
  end

  logic                top_act_s, l_act_s, r_act_s;
  logic [CAPW-1:0]     top_cap_s, l_cap_s, r_cap_s;
  logic [KVW-1:0]      top_kv_s, l_kv_s, r_kv_s;
  logic [CAPW-1:0]     cap_dec_s, cap_inc_s;
  logic                pick_l_s, in_wins_s, in_stays_s;

  // Field decode; a bottom level has no children, so they read as empty.
  always_comb begin
    top_act_s = r_top[EW-1];
    top_cap_s = r_top[EW-2 -: CAPW];
    top_kv_s  = r_top[KVW-1:0];
    if (LAST != 0) begin
      l_act_s = 1'b0;
      l_cap_s = CAP_ZERO;
      l_kv_s  = {KVW{1'b0}};
      r_act_s = 1'b0;
      r_cap_s = CAP_ZERO;
      r_kv_s  = {KVW{1'b0}};
    end else begin
      l_act_s = r_bot_l[EW-1];
      l_cap_s = r_bot_l[EW-2 -: CAPW];
      l_kv_s  = r_bot_l[KVW-1:0];
      r_act_s = r_bot_r[EW-1];
      r_cap_s = r_bot_r[EW-2 -: CAPW];
      r_kv_s  = r_bot_r[KVW-1:0];
    end
    cap_dec_s  = (top_cap_s == CAP_ZERO) ? CAP_ZERO : top_cap_s - CAP_ONE;
    cap_inc_s  = (top_cap_s == CAP_MAX) ? CAP_MAX : top_cap_s + CAP_ONE;
    pick_l_s   = better(l_act_s, l_kv_s[KVW-1 -: KW], r_act_s, r_kv_s[KVW-1 -: KW]);
    in_wins_s  = better(1'b1, kv_r[KVW-1 -: KW], top_act_s, top_kv_s[KVW-1 -: KW]);
    in_stays_s = better(1'b1, kv_r[KVW-1 -: KW], l_act_s, l_kv_s[KVW-1 -: KW]) &&
                 better(1'b1, kv_r[KVW-1 -: KW], r_act_s, r_kv_s[KVW-1 -: KW]);
  end

  logic            e_wen_s, e_ovf_s, e_udf_s;
  logic [EW-1:0]   e_wdata_s;
  logic [1:0]      e_done_s;
  logic [LEVEL-1:0] e_end_s;
  logic [KVW-1:0]  e_out_s;

  // Per-operation result, meaningful only in the evaluate cycle.
  always_comb begin
    e_wen_s   = 1'b0;
    e_ovf_s   = 1'b0;
    e_udf_s   = 1'b0;
    e_wdata_s = {EW{1'b0}};
    e_done_s  = D_DONE;
    e_end_s   = {LEVEL{1'b0}};
    e_out_s   = {KVW{1'b0}};
    case (op_r)
      OP_ENQ: begin
        if (!top_act_s) begin
          e_wen_s   = 1'b1;
          e_wdata_s = {1'b1, cap_dec_s, kv_r};
        end else if (top_cap_s == CAP_ZERO) begin
          e_ovf_s = 1'b1;
        end else begin
          e_wen_s   = 1'b1;
          e_wdata_s = {1'b1, cap_dec_s, (in_wins_s ? kv_r : top_kv_s)};
          e_out_s   = in_wins_s ? top_kv_s : kv_r;
          e_end_s   = {pos_r, (r_cap_s > l_cap_s)};
          e_done_s  = D_NEXT;
        end
      end
      OP_DEQ: begin
        if (!top_act_s) begin
          e_udf_s = 1'b1;
        end else if (!l_act_s && !r_act_s) begin
          e_wen_s   = 1'b1;
          e_out_s   = top_kv_s;
          e_wdata_s = {1'b0, cap_inc_s, {KVW{1'b0}}};
        end else begin
          e_wen_s   = 1'b1;
          e_out_s   = top_kv_s;
          e_wdata_s = {1'b1, cap_inc_s, (pick_l_s ? l_kv_s : r_kv_s)};
          e_end_s   = {pos_r, !pick_l_s};
          e_done_s  = D_NEXT;
        end
      end
      OP_ENQ_DEQ: begin
        e_wen_s = 1'b1;
        if (in_stays_s) begin
          e_wdata_s = {1'b1, top_cap_s, kv_r};
        end else begin
          e_wdata_s = {1'b1, top_cap_s, (pick_l_s ? l_kv_s : r_kv_s)};
          e_out_s   = kv_r;
          e_end_s   = {pos_r, !pick_l_s};
          e_done_s  = D_NEXT;
        end
      end
      default: begin
        e_wen_s = 1'b0;
      end
    endcase
  end

  assign raddr_top = pos_r;
  assign raddr_bot = {pos_r, 1'b0};
  assign waddr_top = pos_r;

  // Output gating: results only in EVAL, reset forces the idle view immediately.
  always_comb begin
    wen_top = 1'b0;
    wdata   = {EW{1'b0}};
    end_pos = {LEVEL{1'b0}};
    out_kv  = {KVW{1'b0}};
    ovf     = 1'b0;
    udf     = 1'b0;
    busy    = 1'b0;
    done    = D_DONE;
    if (rst) begin
      done = D_DONE;
    end else if (state_r == S_EVAL) begin
      busy    = 1'b1;
      wen_top = e_wen_s;
      wdata   = e_wdata_s;
      end_pos = e_end_s;
      out_kv  = e_out_s;
      ovf     = e_ovf_s;
      udf     = e_udf_s;
      done    = e_done_s;
    end else if (state_r == S_RD) begin
      busy = 1'b1;
      done = D_WAIT;
    end else if (start && (op != OP_NOP)) begin
      done = D_WAIT;
    end else begin
      done = D_DONE;
    end
  end

endmodule

// File: tb/tb_pheap_lvl_ctrl.sv
// Bench for pheap_lvl_ctrl: three instances (max-heap, min-heap, bottom level)
// share stimulus and are compared against an entry-level reference model.
module tb_pheap_lvl_ctrl;

  localparam int LEVEL = 3;
  localparam int KW    = 16;
  localparam int VW    = 16;
  localparam int CAPW  = 8;
  localparam int PW    = LEVEL - 1;
  localparam int KVW   = KW + VW;
  localparam int EW    = 1 + CAPW + KVW;

  typedef struct packed {
    logic             wen;
    logic [EW-1:0]    wdata;
    logic [1:0]       done;
    logic [LEVEL-1:0] end_pos;
    logic [KVW-1:0]   out_kv;
    logic             ovf;
    logic             udf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [1:0] op;
  logic [PW-1:0] start_pos;
  logic [KVW-1:0] in_kv;
  logic [EW-1:0] r_top, r_bot_l, r_bot_r;

  logic [PW-1:0]    raddr_top_w [3];
  logic [LEVEL-1:0] raddr_bot_w [3];
  logic             wen_w       [3];
  logic [PW-1:0]    waddr_w     [3];
  logic [EW-1:0]    wdata_w     [3];
  logic             busy_w      [3];
  logic [1:0]       done_w      [3];
  logic [LEVEL-1:0] end_w       [3];
  logic [KVW-1:0]   out_w       [3];
  logic             ovf_w       [3];
  logic             udf_w       [3];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pheap_lvl_ctrl #(.LEVEL(LEVEL), .KW(KW), .VW(VW), .CAPW(CAPW), .MAX_HEAP(1), .LAST(0)) u_max (
    .clk(clk), .rst(rst), .start(start), .op(op), .start_pos(start_pos), .in_kv(in_kv),
    .r_top(r_top), .r_bot_l(r_bot_l), .r_bot_r(r_bot_r),
    .raddr_top(raddr_top_w[0]), .raddr_bot(raddr_bot_w[0]), .wen_top(wen_w[0]),
    .waddr_top(waddr_w[0]), .wdata(wdata_w[0]), .busy(busy_w[0]), .done(done_w[0]),
    .end_pos(end_w[0]), .out_kv(out_w[0]), .ovf(ovf_w[0]), .udf(udf_w[0]));

  pheap_lvl_ctrl #(.LEVEL(LEVEL), .KW(KW), .VW(VW), .CAPW(CAPW), .MAX_HEAP(0), .LAST(0)) u_min (
    .clk(clk), .rst(rst), .start(start), .op(op), .start_pos(start_pos), .in_kv(in_kv),
    .r_top(r_top), .r_bot_l(r_bot_l), .r_bot_r(r_bot_r),
    .raddr_top(raddr_top_w[1]), .raddr_bot(raddr_bot_w[1]), .wen_top(wen_w[1]),
    .waddr_top(waddr_w[1]), .wdata(wdata_w[1]), .busy(busy_w[1]), .done(done_w[1]),
    .end_pos(end_w[1]), .out_kv(out_w[1]), .ovf(ovf_w[1]), .udf(udf_w[1]));

  pheap_lvl_ctrl #(.LEVEL(LEVEL), .KW(KW), .VW(VW), .CAPW(CAPW), .MAX_HEAP(1), .LAST(1)) u_last (
    .clk(clk), .rst(rst), .start(start), .op(op), .start_pos(start_pos), .in_kv(in_kv),
    .r_top(r_top), .r_bot_l(r_bot_l), .r_bot_r(r_bot_r),
    .raddr_top(raddr_top_w[2]), .raddr_bot(raddr_bot_w[2]), .wen_top(wen_w[2]),
    .waddr_top(waddr_w[2]), .wdata(wdata_w[2]), .busy(busy_w[2]), .done(done_w[2]),
    .end_pos(end_w[2]), .out_kv(out_w[2]), .ovf(ovf_w[2]), .udf(udf_w[2]));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [EW-1:0] mk(input int act, input int cap, input logic [KVW-1:0] kv);
    logic [CAPW-1:0] c;
    c = cap[CAPW-1:0];
    return {act[0], c, kv};
  endfunction

  function automatic logic [KVW-1:0] kvk(input int key, input int val);
    return {key[KW-1:0], val[VW-1:0]};
  endfunction

  function automatic int key_of(input logic [KVW-1:0] kv);
    return int'(kv[KVW-1 -: KW]);
  endfunction

  // True when item a may stay ahead of item b in this heap's order.
  function automatic bit wins(input int a_act, input int a_key, input int b_act, input int b_key, input int maxh);
    if (a_act != b_act) return a_act != 0;
    if (a_act == 0) return 1'b1;
    return (maxh != 0) ? (a_key >= b_key) : (a_key <= b_key);
  endfunction

  function automatic exp_t model(input int maxh, input int last, input logic [1:0] o,
                                 input logic [PW-1:0] p, input logic [KVW-1:0] kv,
                                 input logic [EW-1:0] t, input logic [EW-1:0] lc, input logic [EW-1:0] rc);
    exp_t e;
    int ta, tc, la, lcap, ra, rcap, inc, pick_r;
    logic [KVW-1:0] tkv, lkv, rkv, pkv;
    if (last != 0) begin
      lc = '0;
      rc = '0;
    end
    ta = int'(t[EW-1]);  tc = int'(t[EW-2 -: CAPW]);  tkv = t[KVW-1:0];
    la = int'(lc[EW-1]); lcap = int'(lc[EW-2 -: CAPW]); lkv = lc[KVW-1:0];
    ra = int'(rc[EW-1]); rcap = int'(rc[EW-2 -: CAPW]); rkv = rc[KVW-1:0];
    pick_r = wins(la, key_of(lkv), ra, key_of(rkv), maxh) ? 0 : 1;
    pkv = (pick_r != 0) ? rkv : lkv;
    e = '0;
    e.done = 2'd1;
    case (o)
      2'd1: begin
        if (ta == 0) begin
          e.wen = 1'b1;
          e.wdata = mk(1, (tc > 0) ? tc - 1 : 0, kv);
        end else if (tc == 0) begin
          e.ovf = 1'b1;
        end else begin
          e.wen = 1'b1;
          if (wins(1, key_of(kv), 1, key_of(tkv), maxh)) begin
            e.wdata = mk(1, tc - 1, kv);  e.out_kv = tkv;
          end else begin
            e.wdata = mk(1, tc - 1, tkv); e.out_kv = kv;
          end
          e.end_pos = {p, (rcap > lcap) ? 1'b1 : 1'b0};
          e.done = 2'd2;
        end
      end
      2'd2: begin
        if (ta == 0) begin
          e.udf = 1'b1;
        end else begin
          inc = (tc == (1 << CAPW) - 1) ? tc : tc + 1;
          e.wen = 1'b1;
          e.out_kv = tkv;
          if (la == 0 && ra == 0) begin
            e.wdata = mk(0, inc, '0);
          end else begin
            e.wdata = mk(1, inc, pkv);
            e.end_pos = {p, pick_r[0]};
            e.done = 2'd2;
          end
        end
      end
      2'd3: begin
        e.wen = 1'b1;
        if (wins(1, key_of(kv), la, key_of(lkv), maxh) && wins(1, key_of(kv), ra, key_of(rkv), maxh)) begin
          e.wdata = mk(1, tc, kv);
        end else begin
          e.wdata = mk(1, tc, pkv);
          e.out_kv = kv;
          e.end_pos = {p, pick_r[0]};
          e.done = 2'd2;
        end
      end
      default: e.done = 2'd1;
    endcase
    return e;
  endfunction

  // Runs one command and leaves the bench sampling inside its EVAL cycle.
  task automatic run_op(input logic [1:0] o, input logic [PW-1:0] p, input logic [KVW-1:0] kv,
                        input logic [EW-1:0] t, input logic [EW-1:0] lc, input logic [EW-1:0] rc,
                        input bit noise, input bit rst_eval);
    exp_t e;
    start = 1'b1; op = o; start_pos = p; in_kv = kv;
    r_top = $urandom; r_bot_l = $urandom; r_bot_r = $urandom;
    #1;
    chk("start_done_wait", done_w[0], 2'd0);
    @(posedge clk); #1;
    start = 1'b0; op = 2'd0;
    chk("rd_busy", busy_w[0], 1'b1);
    chk("rd_done", done_w[0], 2'd0);
    chk("rd_raddr_top", raddr_top_w[0], p);
    chk("rd_raddr_bot", raddr_bot_w[0], {p, 1'b0});
    chk("rd_wen", wen_w[0], 1'b0);
    if (noise) begin
      start = 1'b1; op = 2'd3; start_pos = ~p; in_kv = ~kv;
    end
    r_top = t; r_bot_l = lc; r_bot_r = rc;
    @(posedge clk); #1;
    start = 1'b0; op = 2'd0;
    #1;
    for (int i = 0; i < 3; i++) begin
      e = model((i != 1) ? 1 : 0, (i == 2) ? 1 : 0, o, p, kv, t, lc, rc);
      chk($sformatf("wen%0d", i),   wen_w[i],   e.wen);
      chk($sformatf("wdata%0d", i), wdata_w[i], e.wdata);
      chk($sformatf("done%0d", i),  done_w[i],  e.done);
      chk($sformatf("end%0d", i),   end_w[i],   e.end_pos);
      chk($sformatf("ovf%0d", i),   ovf_w[i],   e.ovf);
      chk($sformatf("udf%0d", i),   udf_w[i],   e.udf);
      if (!(o == 2'd3 && e.done == 2'd1)) chk($sformatf("out%0d", i), out_w[i], e.out_kv);
    end
    chk("eval_waddr", waddr_w[0], p);
    chk("eval_busy", busy_w[0], 1'b1);
    if (rst_eval) begin
      rst = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) chk($sformatf("rst_eval_wen%0d", i), wen_w[i], 1'b0);
    end
  endtask

  task automatic finish_op();
    @(posedge clk); #1;
    rst = 1'b0;
    chk("back_idle_busy", busy_w[0], 1'b0);
    chk("back_idle_done", done_w[0], 2'd1);
    chk("back_idle_wen", wen_w[0], 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [KVW-1:0] kv5, kv9, kv4, kv8, kv6, kv7, kv3;
    logic [1:0] o;
    logic [EW-1:0] t, lc, rc;
    int caps [4];
    rst = 1'b1; start = 1'b0; op = 2'd0; start_pos = '0; in_kv = '0;
    r_top = '0; r_bot_l = '0; r_bot_r = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_busy", busy_w[0], 1'b0);
    chk("rst_done", done_w[0], 2'd1);
    chk("rst_wen", wen_w[0], 1'b0);
    chk("rst_wdata", wdata_w[0], '0);
    chk("rst_out", out_w[0], '0);
    chk("rst_end", end_w[0], '0);
    chk("rst_ovf", ovf_w[0], 1'b0);
    chk("rst_udf", udf_w[0], 1'b0);
    chk("rst_raddr_top", raddr_top_w[0], '0);
    chk("rst_raddr_bot", raddr_bot_w[0], '0);
    @(posedge clk); #1;

    // NOP start stays idle and reports DONE
    start = 1'b1; op = 2'd0; start_pos = 2'd3;
    #1;
    chk("nop_done", done_w[0], 2'd1);
    @(posedge clk); #1;
    start = 1'b0;
    chk("nop_busy", busy_w[0], 1'b0);

    kv5 = kvk(5, 16'h00AA); kv9 = kvk(9, 16'h0009); kv4 = kvk(4, 16'h0004);
    kv8 = kvk(8, 16'h0008); kv6 = kvk(6, 16'h0006); kv7 = kvk(7, 16'h0007);
    kv3 = kvk(3, 16'h0003);

    run_op(2'd1, 2'd1, kv5, mk(0, 3, '0), mk(0, 0, '0), mk(0, 0, '0), 1'b0, 1'b0);
    chk("enq_empty_wdata", wdata_w[0], mk(1, 2, kv5));
    chk("enq_empty_done", done_w[0], 2'd1);
    finish_op();

    run_op(2'd1, 2'd2, kv9, mk(1, 2, kv4), mk(1, 1, kv6), mk(1, 1, kv7), 1'b0, 1'b0);
    chk("enq_swap_wdata", wdata_w[0], mk(1, 1, kv9));
    chk("enq_swap_out", out_w[0], kv4);
    chk("enq_swap_end", end_w[0], 3'b100);
    chk("enq_swap_done", done_w[0], 2'd2);
    finish_op();

    run_op(2'd2, 2'd3, '0, mk(1, 5, kv8), mk(1, 0, kv6), mk(1, 0, kv7), 1'b1, 1'b0);
    chk("deq_max_out", out_w[0], kv8);
    chk("deq_max_wdata", wdata_w[0], mk(1, 6, kv7));
    chk("deq_max_end", end_w[0], 3'b111);
    chk("deq_min_wdata", wdata_w[1], mk(1, 6, kv6));
    chk("deq_min_end", end_w[1], 3'b110);
    finish_op();
    chk("noise_ignored_busy", busy_w[0], 1'b0);

    run_op(2'd1, 2'd0, kv9, mk(1, 0, kv4), mk(1, 0, kv6), mk(1, 0, kv7), 1'b0, 1'b0);
    chk("ovf_flag", ovf_w[0], 1'b1);
    chk("ovf_nowrite", wen_w[0], 1'b0);
    finish_op();

    run_op(2'd2, 2'd0, '0, mk(0, 4, kv4), mk(1, 0, kv6), mk(1, 0, kv7), 1'b0, 1'b0);
    chk("udf_flag", udf_w[0], 1'b1);
    chk("udf_nowrite", wen_w[0], 1'b0);
    chk("udf_out", out_w[0], '0);
    finish_op();

    run_op(2'd2, 2'd1, '0, mk(1, 255, kv8), mk(0, 0, '0), mk(0, 0, '0), 1'b0, 1'b0);
    chk("deq_sat_wdata", wdata_w[0], mk(0, 255, '0));
    finish_op();

    run_op(2'd2, 2'd2, '0, mk(1, 1, kv8), mk(1, 0, kv6), mk(1, 0, kv7), 1'b0, 1'b1);
    finish_op();

    run_op(2'd3, 2'd2, kv3, mk(1, 2, kv8), mk(1, 0, kvk(10, 1)), mk(1, 0, kvk(11, 2)), 1'b0, 1'b0);
    chk("last_ed_wdata", wdata_w[2], mk(1, 2, kv3));
    chk("last_ed_done", done_w[2], 2'd1);
    chk("max_ed_wdata", wdata_w[0], mk(1, 2, kvk(11, 2)));
    finish_op();

    caps[0] = 0; caps[1] = 1; caps[2] = 255; caps[3] = 0;
    for (int n = 0; n < 60; n++) begin
      o = 2'($urandom_range(1, 3));
      caps[3] = $urandom_range(0, 255);
      t  = mk(($urandom % 4) != 0, caps[$urandom % 4], kvk($urandom_range(0, 15), $urandom));
      lc = mk(($urandom % 3) != 0, caps[$urandom % 4], kvk($urandom_range(0, 15), $urandom));
      rc = mk(($urandom % 3) != 0, caps[$urandom % 4], kvk($urandom_range(0, 15), $urandom));
      run_op(o, 2'($urandom), kvk($urandom_range(0, 15), $urandom), t, lc, rc,
             ($urandom % 4) == 0, ($urandom % 8) == 0);
      finish_op();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pheap_lvl_ctrl.md
PHEAP_LVL_CTRL -- requirements
Module: pheap_lvl_ctrl

Interface
REQ-001 SHALL have parameter LEVEL, default 2, heap level index (>=2); level holds 2^(LEVEL-1) entries.
REQ-002 SHALL have parameter KW, default 16, key width.
REQ-003 SHALL have parameter VW, default 16, value width.
REQ-004 SHALL have parameter CAPW, default 8, subtree free-capacity width.
REQ-005 SHALL have parameter MAX_HEAP, default 1, 1 = max-heap, 0 = min-heap.
REQ-006 SHALL have parameter LAST, default 0, 1 = bottom level (no children exist).
REQ-007 Entry format E, EW = 1+CAPW+KW+VW bits, MSB first: {active, cap, key, val}; KV = {key, val}.
REQ-008 SHALL have clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-009 SHALL have start  in  1, op  in  2 (0 NOP, 1 ENQ, 2 DEQ, 3 ENQ_DEQ), start_pos  in  LEVEL-1, in_kv  in  KW+VW.
REQ-010 SHALL have r_top  in  EW, r_bot_l  in  EW, r_bot_r  in  EW; synchronous-read memory data, valid one cycle after address.
REQ-011 SHALL have raddr_top  out  LEVEL-1, raddr_bot  out  LEVEL (left-child address), wen_top  out  1, waddr_top  out  LEVEL-1, wdata  out  EW.
REQ-012 SHALL have busy  out  1, done  out  2 (0 WAIT, 1 DONE, 2 NEXT_LEVEL), end_pos  out  LEVEL, out_kv  out  KW+VW, ovf  out  1, udf  out  1.

Function
REQ-013 States: IDLE, RD, EVAL; IDLE->RD on start && op!=NOP; RD->EVAL unconditionally; EVAL->IDLE unconditionally.
REQ-014 Accepting start in IDLE SHALL register op, start_pos, in_kv; start in RD/EVAL is ignored; start with op NOP leaves FSM in IDLE, done = DONE.
REQ-015 raddr_top = registered pos, raddr_bot = {pos,0} in RD; waddr_top = registered pos.
REQ-016 busy = 1 in RD and EVAL; done = WAIT in RD and in the cycle of an accepted start, else DONE outside EVAL.
REQ-017 done, end_pos, out_kv, wen_top, wdata, ovf, udf SHALL be valid only in EVAL (latency: start cycle t -> EVAL at t+2); outside EVAL wen_top/ovf/udf = 0, out_kv/end_pos/wdata = 0.
REQ-018 better(a,b): active beats inactive; both active -> key greater (MAX_HEAP=1) or smaller (MAX_HEAP=0); ties favour first argument.
REQ-019 LAST=1: r_bot_l/r_bot_r SHALL be treated as inactive, cap 0.
REQ-020 ENQ, top inactive: write {1, top.cap-1 sat 0, in_kv}, done = DONE.
REQ-021 ENQ, top active, top.cap = 0: no write, ovf = 1, done = DONE, in_kv dropped.
REQ-022 ENQ, top active, cap>0: winner of better(in,top) stays on top with cap-1; loser -> out_kv; end_pos = child with larger cap (tie left, zero-cap child never chosen); done = NEXT_LEVEL.
REQ-023 DEQ, top inactive: no write, udf = 1, out_kv = 0, done = DONE.
REQ-024 DEQ, top active: out_kv = top KV; cap+1 saturating at 2^CAPW-1; no active child -> write inactive KV 0, done = DONE; else promote better(L,R) child KV, end_pos = that child, done = NEXT_LEVEL.
REQ-025 ENQ_DEQ: cap unchanged; in better-or-equal than both children -> write in_kv, done = DONE; else promote better(L,R), out_kv = in_kv, end_pos = that child, done = NEXT_LEVEL.
REQ-026 end_pos = {pos,0} for left, {pos,1} for right.

Reset
REQ-027 rst SHALL have priority over all activity: state = IDLE, registers cleared, wen_top = 0 in any reset cycle including mid-operation.
REQ-028 After reset: busy 0, done DONE, all other outputs 0.

Verification
REQ-029 ENQ key 5 into inactive top, cap 3 -> EVAL at t+2: wdata {1,2,5,v}, done DONE.
REQ-030 MAX_HEAP=1, ENQ key 9, top {1,2,4}, L.cap 1, R.cap 1 -> top key 9 cap 1, out_kv key 4, end_pos left, NEXT_LEVEL.
REQ-031 DEQ top key 8, L key 6, R key 7 -> out key 8, wdata key 7 cap+1, end_pos right; MAX_HEAP=0 same data -> promote key 6, left.
REQ-032 ENQ into full top (cap 0) -> ovf 1, no write; DEQ inactive top -> udf 1, no write.
REQ-033 rst asserted in EVAL of DEQ -> wen_top 0 that cycle, IDLE next; start during RD ignored.
REQ-034 LAST=1, ENQ_DEQ key 3 -> write key 3, done DONE.
